// File: rtl/bip_core_mc.sv
// bip_core_mc: multicycle BIP-I accumulator core.
// FETCH latches the program word, EXEC performs it. Memory operations may be
// stretched by the data memory through i_DmReady. Run and single-step control
// are provided, and a saturating counter records the cycles spent busy.
module bip_core_mc #(
  parameter int unsigned NBITS_O   = 11,
  parameter int unsigned OPCODE    = 5,
  parameter int unsigned NBITS_D   = 16,
  parameter int unsigned NBITS_CNT = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic                 i_step,
  output logic [NBITS_O-1:0]   o_PmAddr,
  input  logic [NBITS_D-1:0]   i_Instruction,
  output logic [NBITS_O-1:0]   o_DmAddr,
  output logic                 o_Rd,
  output logic                 o_Wr,
  output logic [NBITS_D-1:0]   o_InData,
  input  logic [NBITS_D-1:0]   i_OutData,
  input  logic                 i_DmReady,
  output logic [NBITS_D-1:0]   o_ACC,
  output logic                 o_Halt,
  output logic                 o_Busy,
  output logic [NBITS_CNT-1:0] o_CycleCount
);

  localparam logic [OPCODE-1:0] OpHlt  = OPCODE'(0);
  localparam logic [OPCODE-1:0] OpSto  = OPCODE'(1);
  localparam logic [OPCODE-1:0] OpLd   = OPCODE'(2);
  localparam logic [OPCODE-1:0] OpLdi  = OPCODE'(3);
  localparam logic [OPCODE-1:0] OpAdd  = OPCODE'(4);
  localparam logic [OPCODE-1:0] OpAddi = OPCODE'(5);
  localparam logic [OPCODE-1:0] OpSub  = OPCODE'(6);
  localparam logic [OPCODE-1:0] OpSubi = OPCODE'(7);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  state_e               r_state;
  logic [NBITS_O-1:0]   r_pc;
  logic [NBITS_O-1:0]   r_dm_addr;
  logic [NBITS_D-1:0]   r_ir;
  logic [NBITS_D-1:0]   r_acc;
  logic [NBITS_CNT-1:0] r_cnt;
  logic                 r_busy;
  logic                 r_halt;

  logic [OPCODE-1:0]    w_opcode;
  logic [OPCODE-1:0]    w_fetch_opcode;
  logic [NBITS_O-1:0]   w_operand;
  logic [NBITS_D-1:0]   w_imm;
  logic                 w_is_rd;
  logic                 w_is_wr;
  logic                 w_exec_done;

  function automatic logic is_mem_op(input logic [OPCODE-1:0] op);
    return (op == OpSto) || (op == OpLd) || (op == OpAdd) || (op == OpSub);
  endfunction

  assign w_opcode       = r_ir[NBITS_D-1:NBITS_O];
  assign w_operand      = r_ir[NBITS_O-1:0];
  assign w_imm          = {{(NBITS_D-NBITS_O){w_operand[NBITS_O-1]}}, w_operand};
  assign w_fetch_opcode = i_Instruction[NBITS_D-1:NBITS_O];

  // Data strobes are decoded straight from the state so reset kills them at once.
  assign w_is_rd = (r_state == StExec) &&
                   ((w_opcode == OpLd) || (w_opcode == OpAdd) || (w_opcode == OpSub));
  assign w_is_wr = (r_state == StExec) && (w_opcode == OpSto);

  // Non-memory instructions finish in one EXEC cycle; memory ones wait for ready.
  assign w_exec_done = (r_state == StExec) && (!(w_is_rd || w_is_wr) || i_DmReady);

  assign o_PmAddr     = r_pc;
  assign o_DmAddr     = r_dm_addr;
  assign o_Rd         = w_is_rd;
  assign o_Wr         = w_is_wr;
  assign o_InData     = r_acc;
  assign o_ACC        = r_acc;
  assign o_Halt       = r_halt;
  assign o_Busy       = r_busy;
  assign o_CycleCount = r_cnt;

  // Control FSM together with the datapath registers and the cycle counter.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_pc      <= '0;
      r_dm_addr <= '0;
      r_ir      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_halt    <= 1'b0;
    end else begin
      if (((r_state == StFetch) || (r_state == StExec)) && (r_cnt != {NBITS_CNT{1'b1}})) begin
        r_cnt <= r_cnt + NBITS_CNT'(1);
      end
      case (r_state)
        StIdle: begin
          if (i_run || i_step) begin
            r_state <= StFetch;
            r_busy  <= 1'b1;
          end
        end
        StFetch: begin
          r_ir <= i_Instruction;
          // Address is loaded only for memory ops so it holds across other instructions.
          if (is_mem_op(w_fetch_opcode)) begin
            r_dm_addr <= i_Instruction[NBITS_O-1:0];
          end
          r_state <= StExec;
        end
        StExec: begin
          if (w_opcode == OpHlt) begin
            r_state <= StHalt;
            r_busy  <= 1'b0;
            r_halt  <= 1'b1;
          end else if (w_exec_done) begin
            case (w_opcode)
              OpLd:    r_acc <= i_OutData;
              OpLdi:   r_acc <= w_imm;
              OpAdd:   r_acc <= r_acc + i_OutData;
              OpAddi:  r_acc <= r_acc + w_imm;
              OpSub:   r_acc <= r_acc - i_OutData;
              OpSubi:  r_acc <= r_acc - w_imm;
              default: ;
            endcase
            r_pc <= r_pc + NBITS_O'(1);
            if (i_run) begin
              r_state <= StFetch;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end
        end
        StHalt: ;
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bip_core_mc.md
# bip_core_mc

Multicycle, parametrised successor of the BIP accumulator processor.
- Executes the BIP-I instruction set with a fetch/execute state machine on one clock.
- Adds run/single-step control, data-memory wait states via a ready handshake, and a saturating cycle counter.
- Sits between the program memory (combinational read) and a data memory that may stall.
- Instantiated by the BIP top level in place of the single-cycle cpu.

## Interface

Parameters:
- NBITS_O, 11, operand/address width (PC, program and data address).
- OPCODE, 5, opcode width; NBITS_D must equal OPCODE + NBITS_O.
- NBITS_D, 16, data/instruction/accumulator width.
- NBITS_CNT, 32, cycle counter width.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_run  in  1  level; 1 = execute continuously.
- i_step  in  1  sampled in IDLE only; 1 with i_run=0 executes exactly one instruction.
- o_PmAddr  out  NBITS_O  program memory address (= PC).
- i_Instruction  in  NBITS_D  program word at o_PmAddr, valid the same cycle.
- o_DmAddr  out  NBITS_O  data memory address.
- o_Rd  out  1  data read strobe.
- o_Wr  out  1  data write strobe.
- o_InData  out  NBITS_D  write data (= ACC).
- i_OutData  in  NBITS_D  read data, valid when i_DmReady=1.
- i_DmReady  in  1  data memory completes the current o_Rd/o_Wr access this cycle.
- o_ACC  out  NBITS_D  accumulator.
- o_Halt  out  1  1 once HLT has executed.
- o_Busy  out  1  1 in FETCH or EXEC.
- o_CycleCount  out  NBITS_CNT  cycles spent in FETCH/EXEC.

## Operation

Instruction format: IR[NBITS_D-1:NBITS_O] is the opcode; IR[NBITS_O-1:0] is the operand (address, or immediate sign-extended to NBITS_D).

Opcodes:
- 0 HLT
- 1 STO: mem[op]←ACC
- 2 LD: ACC←mem[op]
- 3 LDI: ACC←imm
- 4 ADD: ACC+=mem[op]
- 5 ADDI: ACC+=imm
- 6 SUB: ACC-=mem[op]
- 7 SUBI: ACC-=imm
- Any other opcode: NOP (PC+1).

State machine:
- IDLE → FETCH when i_run=1, or when i_step=1 and i_run=0.
- FETCH: IR←i_Instruction; → EXEC.
- EXEC, immediate/NOP: update ACC, PC←PC+1, then → FETCH if i_run=1, else → IDLE.
- EXEC, memory op: o_Rd (LD/ADD/SUB) or o_Wr (STO) asserted combinationally, with o_DmAddr=operand. Stay in EXEC while i_DmReady=0. When i_DmReady=1, complete (ACC update for reads), PC←PC+1, then take the next state as for immediates.
- EXEC, HLT: → HALT; PC is not incremented.
- HALT: absorbing; o_Halt=1. It leaves only on reset; i_run and i_step are ignored.

Rules:
- Arithmetic is modulo 2^NBITS_D, with no flags.
- PC wraps from 2^NBITS_O−1 to 0.
- Dropping i_run mid-instruction completes the current instruction, then goes to IDLE.
- i_run=1 dominates i_step.
- o_DmAddr holds its last value outside memory operations.

## Timing

- Reset (asynchronous, i_reset=0): state IDLE, PC=0, IR=0, ACC=0, o_DmAddr=0, o_Rd=o_Wr=0, o_Halt=0, o_Busy=0, o_CycleCount=0.
- Release from reset is synchronous to the next rising edge.
- Each instruction takes 2 cycles (FETCH+EXEC), plus one cycle per cycle of i_DmReady=0 during a memory EXEC.
- o_Rd/o_Wr are high only in EXEC and never simultaneously. o_Wr drops in the cycle after i_DmReady=1.
- o_CycleCount increments on every edge taken in FETCH or EXEC. It is frozen in IDLE/HALT and saturates at 2^NBITS_CNT−1.
- o_Halt rises the cycle after HLT's EXEC.
- Reset asserted mid-access drops o_Rd/o_Wr immediately; any partial ACC update is discarded.

## Test plan

- Program LDI 5; ADDI 0x7FE; STO 3; ADD 3; HLT, with i_run=1 and i_DmReady=1. Expect ACC=6, mem[3]=3, o_Halt=1, o_CycleCount=10, PC=4.
- Same program with i_DmReady=0 for 3 cycles during STO. Expect o_Wr held 4 cycles, o_DmAddr=3, o_CycleCount=13, identical final state.
- mem[0]=0x7FFF; LD 0; ADDI 1 → ACC=0x8000. Then SUBI 1 → ACC=0x7FFF.
- Step mode: i_run=0, four 1-cycle i_step pulses on the first program. Expect PC to advance 0→1→2→3→4, o_Busy high exactly 2 cycles per step, and ACC=6 after the fourth step.
- NBITS_O=4 (NBITS_D=9): 16 NOP words with i_run=1. Expect PC to wrap 15→0 and o_Halt to stay 0.
- Assert i_reset=0 mid-access, during a LD wait state. Expect o_Rd=0, ACC=0, PC=0 and o_CycleCount=0 asynchronously; after release the program restarts from address 0.
